// File: rtl/reg_bank_display_scanner_if.sv
// Signal bundle between a register-bank source/board pins and the display scanner.
// The master side drives the bank and controls; the slave side is the scanner.
interface reg_bank_display_scanner_if #(
    parameter int DATA_W     = 9,
    parameter int NUM_REGS   = 8,
    parameter int SEL_W      = 3,
    parameter int NUM_DIGITS = 3
);
    logic [NUM_REGS*DATA_W-1:0] regs;
    logic                       step_key_n;
    logic                       auto_mode;
    logic                       freeze;
    logic [SEL_W-1:0]           sel;
    logic [DATA_W-1:0]          data;
    logic [7*NUM_DIGITS-1:0]    hex;
    logic                       step_pulse;

    modport master (
        output regs, step_key_n, auto_mode, freeze,
        input  sel, data, hex, step_pulse
    );

    modport slave (
        input  regs, step_key_n, auto_mode, freeze,
        output sel, data, hex, step_pulse
    );
endinterface

// File: rtl/reg_bank_display_scanner.sv
// Register-bank viewer: debounced single-step or timed auto-scan selection of one
// register, registered readout and active-low seven-segment hex digits.
module reg_bank_display_scanner #(
    parameter int DATA_W          = 9,
    parameter int NUM_REGS        = 8,
    parameter int SEL_W           = 3,
    parameter int NUM_DIGITS      = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_CYCLES     = 50000000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    reg_bank_display_scanner_if.slave   bus
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SC_W  = $clog2(SCAN_CYCLES + 1);
    localparam int PAD_W = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} db_state_e;

    logic [1:0]         key_sync_q;
    db_state_e          state_q, state_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [SC_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic               auto_prev_q;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               step_pulse_q;
    logic               key_s, press_evt, tick, advance;

    logic [DATA_W-1:0]      reg_words [NUM_REGS];
    logic [PAD_W-1:0]       data_pad;
    logic [7*NUM_DIGITS-1:0] hex_w;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_word
            assign reg_words[gi] = bus.regs[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign key_s = key_sync_q[1];

    // Debounce: a level change is accepted only after it persists DEBOUNCE_CYCLES checks.
    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        press_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d  = PRESS_CHK;
                    db_cnt_d = '0;
                end
            end
            PRESS_CHK: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d   = HELD;
                    press_evt = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                if (key_s) begin
                    state_d  = REL_CHK;
                    db_cnt_d = '0;
                end
            end
            REL_CHK: begin
                if (!key_s) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Any AutoMode edge restarts the dwell so the first tick is a full period away.
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        tick       = 1'b0;
        if (bus.auto_mode != auto_prev_q) begin
            scan_cnt_d = '0;
        end else if (bus.auto_mode && !bus.freeze) begin
            if (scan_cnt_q == SC_W'(SCAN_CYCLES - 1)) begin
                scan_cnt_d = '0;
                tick       = 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + SC_W'(1);
            end
        end
    end

    assign advance = (press_evt || tick) && !bus.freeze;

    always_comb begin
        sel_d  = sel_q;
        data_d = data_q;
        if (advance) begin
            sel_d = (sel_q == SEL_W'(NUM_REGS - 1)) ? '0 : sel_q + SEL_W'(1);
        end
        if (!bus.freeze) begin
            data_d = reg_words[sel_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_sync_q   <= 2'b11;
            state_q      <= IDLE;
            db_cnt_q     <= '0;
            scan_cnt_q   <= '0;
            auto_prev_q  <= 1'b0;
            sel_q        <= '0;
            data_q       <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            key_sync_q   <= {key_sync_q[0], bus.step_key_n};
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            scan_cnt_q   <= scan_cnt_d;
            auto_prev_q  <= bus.auto_mode;
            sel_q        <= sel_d;
            data_q       <= data_d;
            step_pulse_q <= advance;
        end
    end

    assign data_pad = PAD_W'(data_q);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign hex_w[7*gi +: 7] = seg7(data_pad[4*gi +: 4]);
        end
    endgenerate

    assign bus.sel        = sel_q;
    assign bus.data       = data_q;
    assign bus.hex        = hex_w;
    assign bus.step_pulse = step_pulse_q;
endmodule
